regfile_mp: RTL and testbench

Parametrised multi-port integer register file, the successor to the single-write, two-read register file in the core. It adds configurable width, depth, read and write port counts, and an asynchronous active-low reset that clears the array. It also adds optional write-to-read bypass, optional registered (1-cycle) reads, and a per-register busy scoreboard for in-flight destination tracking. It sits between decode (reads, issue) and writeback (writes) in the pipelined core.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 55 +++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and constants for the multi-port register file
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int ZERO_REG  = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read, write and issue signal bundle of the register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = AW_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 1
);

    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                issue_vld;
    logic [AW-1:0]       issue_rd;
    logic                issue_waw;

    modport master (
        output raddr, we, waddr, wdata, issue_vld, issue_rd,
        input  rdata, rbusy, issue_waw
    );

    modport slave (
        input  raddr, we, waddr, wdata, issue_vld, issue_rd,
        output rdata, rbusy, issue_waw
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits tracking in-flight destinations
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] raddr,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              issue_vld,
    input  logic [AW-1:0]     issue_rd,
    output logic [NRD-1:0]    rbusy,
    output logic              issue_waw
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_vld && issue_rd != AW'(ZERO_REG))
            set_vec[issue_rd] = 1'b1;
        for (int j = 0; j < NWR; j++)
            if (we[j] && waddr[j*AW +: AW] != AW'(ZERO_REG))
                clr_vec[waddr[j*AW +: AW]] = 1'b1;
    end

    // Set is ORed in after the clear: a fresh issue supersedes the retiring producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= (busy & ~clr_vec) | set_vec;
    end

    assign issue_waw = set_vec[issue_rd] & busy[issue_rd];

    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            rbusy[i] = busy[raddr[i*AW +: AW]];
            if (BYPASS != 0 && clr_vec[raddr[i*AW +: AW]] && !set_vec[raddr[i*AW +: AW]])
                rbusy[i] = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass and busy scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREGS     = NREGS_DEF,
    parameter int NRD       = 2,
    parameter int NWR       = 1,
    parameter int BYPASS    = 1,
    parameter int SYNC_READ = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs [NREGS];
    logic [NRD*XLEN-1:0] rsel;
    logic [NRD-1:0]      busy_sel;

    // Later ports are assigned last, so the highest enabled port wins an address clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (bus.we[j] && bus.waddr[j*AW +: AW] != AW'(ZERO_REG))
                    regs[bus.waddr[j*AW +: AW]] <= bus.wdata[j*XLEN +: XLEN];
        end
    end

    always_comb begin
        rsel = '0;
        for (int i = 0; i < NRD; i++) begin
            rsel[i*XLEN +: XLEN] = regs[bus.raddr[i*AW +: AW]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++)
                    if (bus.we[j] && bus.raddr[i*AW +: AW] != AW'(ZERO_REG)
                        && bus.waddr[j*AW +: AW] == bus.raddr[i*AW +: AW])
                        rsel[i*XLEN +: XLEN] = bus.wdata[j*XLEN +: XLEN];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr     (bus.raddr),
        .we        (bus.we),
        .waddr     (bus.waddr),
        .issue_vld (bus.issue_vld),
        .issue_rd  (bus.issue_rd),
        .rbusy     (busy_sel),
        .issue_waw (bus.issue_waw)
    );

    generate
        if (SYNC_READ != 0) begin : g_sync_read
            logic [NRD*XLEN-1:0] rdata_q;
            logic [NRD-1:0]      rbusy_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    rbusy_q <= '0;
                end else begin
                    rdata_q <= rsel;
                    rbusy_q <= busy_sel;
                end
            end

            assign bus.rdata = rdata_q;
            assign bus.rbusy = rbusy_q;
        end else begin : g_comb_read
            assign bus.rdata = rsel;
            assign bus.rbusy = busy_sel;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp in three configurations
module tb_regfile_mp;

    logic clk;
    logic rst_n;
    logic rst_c;
    int   pass_cnt;
    int   total_cnt;

    // a: dual write, bypass, comb read; b: no bypass; c: registered read with bypass
    regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2), .NWR(2)) ia ();
    regfile_mp_if #(.XLEN(32), .AW(5), .NRD(1), .NWR(1)) ib ();
    regfile_mp_if #(.XLEN(32), .AW(5), .NRD(1), .NWR(1)) ic ();

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .SYNC_READ(0))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(1), .NWR(1), .BYPASS(0), .SYNC_READ(0))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(1), .NWR(1), .BYPASS(1), .SYNC_READ(1))
        u_dut_c (.clk(clk), .rst_n(rst_c), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        rst_c = 1'b0;
        ia.raddr = '0; ia.we = '0; ia.waddr = '0; ia.wdata = '0; ia.issue_vld = 1'b0; ia.issue_rd = '0;
        ib.raddr = '0; ib.we = '0; ib.waddr = '0; ib.wdata = '0; ib.issue_vld = 1'b0; ib.issue_rd = '0;
        ic.raddr = '0; ic.we = '0; ic.waddr = '0; ic.wdata = '0; ic.issue_vld = 1'b0; ic.issue_rd = '0;

        repeat (2) @(negedge clk);
        check("rst_a_rdata", ia.rdata, 64'h0);
        check("rst_a_rbusy", ia.rbusy, 64'h0);
        check("rst_c_rdata", ic.rdata, 64'h0);
        rst_n = 1'b1;
        rst_c = 1'b1;

        // preload x5/x31 and mark x5 busy, then reset and expect a clean file
        @(negedge clk);
        ia.we = 2'b11; ia.waddr = {5'd31, 5'd5}; ia.wdata = {32'h3131, 32'h55};
        ia.issue_vld = 1'b1; ia.issue_rd = 5'd5;
        @(negedge clk);
        ia.we = '0; ia.issue_vld = 1'b0; ia.raddr = {5'd31, 5'd5};
        #1;
        check("pre_rst_x5", ia.rdata[31:0], 64'h55);
        check("pre_rst_x31", ia.rdata[63:32], 64'h3131);
        check("pre_rst_busy", ia.rbusy, 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_rdata", ia.rdata, 64'h0);
        check("async_rst_rbusy", ia.rbusy, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_rdata", ia.rdata, 64'h0);
        check("post_rst_rbusy", ia.rbusy, 64'h0);

        // x0 protection
        @(negedge clk);
        ia.we = 2'b01; ia.waddr = '0; ia.wdata = {32'h0, 32'hDEADBEEF}; ia.raddr = '0;
        ia.issue_vld = 1'b1; ia.issue_rd = 5'd0;
        #1;
        check("x0_no_bypass", ia.rdata[31:0], 64'h0);
        check("x0_waw", ia.issue_waw, 64'h0);
        @(negedge clk);
        ia.we = '0;
        #1;
        check("x0_read", ia.rdata[31:0], 64'h0);
        check("x0_rbusy", ia.rbusy, 64'h0);
        check("x0_waw2", ia.issue_waw, 64'h0);
        ia.issue_vld = 1'b0;

        // write-to-read bypass
        @(negedge clk);
        ia.we = 2'b01; ia.waddr = {5'd0, 5'd7}; ia.wdata = {32'h0, 32'h11};
        @(negedge clk);
        ia.we = '0; ia.raddr = {5'd0, 5'd7};
        #1;
        check("byp_old", ia.rdata[31:0], 64'h11);
        @(negedge clk);
        ia.we = 2'b01; ia.wdata = {32'h0, 32'h22};
        #1;
        check("byp_same_cycle", ia.rdata[31:0], 64'h22);
        @(negedge clk);
        ia.we = '0;
        #1;
        check("byp_stored", ia.rdata[31:0], 64'h22);

        // both ports write x3: port 1 wins
        @(negedge clk);
        ia.we = 2'b11; ia.waddr = {5'd3, 5'd3}; ia.wdata = {32'h5555, 32'hAAAA};
        ia.raddr = {5'd3, 5'd7};
        #1;
        check("dual_byp", ia.rdata[63:32], 64'h5555);
        check("dual_other_port", ia.rdata[31:0], 64'h22);
        @(negedge clk);
        ia.we = '0;
        #1;
        check("dual_stored", ia.rdata[63:32], 64'h5555);

        // scoreboard on x9
        @(negedge clk);
        ia.issue_vld = 1'b1; ia.issue_rd = 5'd9; ia.raddr = {5'd9, 5'd9};
        #1;
        check("sb_idle_rbusy", ia.rbusy, 64'h0);
        check("sb_idle_waw", ia.issue_waw, 64'h0);
        @(negedge clk);
        #1;
        check("sb_busy", ia.rbusy, 64'h3);
        check("sb_waw", ia.issue_waw, 64'h1);
        @(negedge clk);
        ia.we = 2'b01; ia.waddr = {5'd0, 5'd9}; ia.wdata = {32'h0, 32'h99};
        #1;
        check("sb_wr_issue_waw", ia.issue_waw, 64'h1);
        check("sb_wr_issue_rbusy", ia.rbusy, 64'h3);
        check("sb_wr_issue_rdata", ia.rdata[31:0], 64'h99);
        @(negedge clk);
        ia.issue_vld = 1'b0; ia.we = 2'b10; ia.waddr = {5'd9, 5'd0}; ia.wdata = {32'h98, 32'h0};
        #1;
        check("sb_clr_fwd_rbusy", ia.rbusy, 64'h0);
        check("sb_clr_waw", ia.issue_waw, 64'h0);
        check("sb_clr_rdata", ia.rdata[31:0], 64'h98);
        @(negedge clk);
        ia.we = '0;
        #1;
        check("sb_cleared", ia.rbusy, 64'h0);
        check("sb_cleared_rdata", ia.rdata[31:0], 64'h98);

        // no-bypass instance
        @(negedge clk);
        ib.we = 1'b1; ib.waddr = 5'd7; ib.wdata = 32'h11;
        @(negedge clk);
        ib.wdata = 32'h22; ib.raddr = 5'd7;
        #1;
        check("nobyp_old", ib.rdata, 64'h11);
        @(negedge clk);
        ib.we = 1'b0;
        #1;
        check("nobyp_new", ib.rdata, 64'h22);
        @(negedge clk);
        ib.issue_vld = 1'b1; ib.issue_rd = 5'd8; ib.raddr = 5'd8;
        @(negedge clk);
        ib.issue_vld = 1'b0; ib.we = 1'b1; ib.waddr = 5'd8; ib.wdata = 32'h88;
        #1;
        check("nobyp_busy", ib.rbusy, 64'h1);
        check("nobyp_rdata_old", ib.rdata, 64'h0);
        @(negedge clk);
        ib.we = 1'b0;
        #1;
        check("nobyp_cleared", ib.rbusy, 64'h0);
        check("nobyp_rdata_new", ib.rdata, 64'h88);

        // registered-read instance
        @(negedge clk);
        ic.we = 1'b1; ic.waddr = 5'd4; ic.wdata = 32'h1234;
        @(negedge clk);
        ic.we = 1'b0; ic.raddr = 5'd4;
        #1;
        check("sync_lat0", ic.rdata, 64'h0);
        @(negedge clk);
        #1;
        check("sync_lat1", ic.rdata, 64'h1234);
        @(negedge clk);
        ic.we = 1'b1; ic.wdata = 32'h5678;
        #1;
        check("sync_hold", ic.rdata, 64'h1234);
        @(negedge clk);
        ic.we = 1'b0;
        #1;
        check("sync_byp", ic.rdata, 64'h5678);
        rst_c = 1'b0;
        #1;
        check("sync_async_rst", ic.rdata, 64'h0);
        @(negedge clk);
        rst_c = 1'b1; ic.issue_vld = 1'b1; ic.issue_rd = 5'd10; ic.raddr = 5'd10;
        @(negedge clk);
        ic.issue_vld = 1'b0;
        #1;
        check("sync_busy_lat", ic.rbusy, 64'h0);
        @(negedge clk);
        #1;
        check("sync_busy", ic.rbusy, 64'h1);
        ic.raddr = 5'd4;
        @(negedge clk);
        #1;
        check("sync_x4_after_rst", ic.rdata, 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
